// File: rtl/potential_decay_pkg.sv
// ============================================================================
//  Module   : potential_decay_pkg
//  Purpose  : Shared FP32 field positions, sweep state type and the reference
//             power-of-two decay function for the potential decay engine.
//  Config   : POTENTIAL_DECAY_SUBNORMAL_EN selects gradual underflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package potential_decay_pkg;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_MAN_LSB  = 0;
    localparam logic [7:0] EXP_MAX = 8'd255;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

    // Divide an FP32 value by 2^rate; Inf/NaN and rate 0 pass through.
    function automatic logic [31:0] decay_fp32(input logic [31:0] value,
                                               input logic [31:0] rate);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = value[FP32_SIGN_BIT];
        e = value[FP32_EXP_MSB:FP32_EXP_LSB];
        m = value[FP32_MAN_MSB:FP32_MAN_LSB];
        decay_fp32 = value;
        if (rate == 32'd0 || e == EXP_MAX) begin
            decay_fp32 = value;
        end else if ({24'd0, e} > rate) begin
            decay_fp32 = {s, 8'({24'd0, e} - rate), m};
        end else begin
`ifdef POTENTIAL_DECAY_SUBNORMAL_EN
            if (e == 8'd0) begin
                decay_fp32 = {s, 8'd0, 23'(m >> rate)};
            end else begin
                decay_fp32 = {s, 8'd0, 23'({1'b1, m} >> (rate - {24'd0, e} + 32'd1))};
            end
`else
            decay_fp32 = {s, 31'd0};
`endif
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_pow2_divider.sv
// ============================================================================
//  Module   : fp32_pow2_divider
//  Purpose  : Combinational FP32 divide-by-2^rate datapath (exponent subtract
//             with underflow handling).
//  Config   : POTENTIAL_DECAY_SUBNORMAL_EN -> gradual underflow into
//             subnormals; otherwise underflow flushes to signed zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp32_pow2_divider
    import potential_decay_pkg::*;
#(
    parameter int RATE_WIDTH = 3
) (
    input  logic [31:0]           i_value,
    input  logic [RATE_WIDTH-1:0] i_rate,
    output logic [31:0]           o_result
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [31:0] w_rate;
    logic        w_passthru;
    logic        w_normal;
    logic [31:0] w_norm_res;
    logic [31:0] w_uflow_res;

    assign w_sign = i_value[FP32_SIGN_BIT];
    assign w_exp  = i_value[FP32_EXP_MSB:FP32_EXP_LSB];
    assign w_man  = i_value[FP32_MAN_MSB:FP32_MAN_LSB];
    assign w_rate = 32'(i_rate);

    // Rate 0 and Inf/NaN are returned untouched.
    assign w_passthru = (w_rate == 32'd0) || (w_exp == EXP_MAX);
    // Exponent stays >= 1 after the subtract: result remains normal.
    assign w_normal   = ({24'd0, w_exp} > w_rate);
    assign w_norm_res = {w_sign, 8'({24'd0, w_exp} - w_rate), w_man};

`ifdef POTENTIAL_DECAY_SUBNORMAL_EN
    logic [31:0] w_shamt;
    // Normal inputs bring their hidden bit down into the subnormal mantissa.
    assign w_shamt     = w_rate - {24'd0, w_exp} + 32'd1;
    assign w_uflow_res = (w_exp == 8'd0)
                       ? {w_sign, 8'd0, 23'(w_man >> w_rate)}
                       : {w_sign, 8'd0, 23'({1'b1, w_man} >> w_shamt)};
`else
    assign w_uflow_res = {w_sign, 31'd0};
`endif

    assign o_result = w_passthru ? i_value
                    : w_normal   ? w_norm_res
                    :              w_uflow_res;

endmodule

`default_nettype wire

// File: rtl/potential_decay_engine.sv
// ============================================================================
//  Module   : potential_decay_engine
//  Purpose  : Neuron potential table with per-neuron 2^-rate decay. A TIMESTEP
//             pulse sweeps all neurons, streaming decayed values over a
//             valid/ready port and writing them back into the table.
//  Config   : POTENTIAL_DECAY_SUBNORMAL_EN (in fp32_pow2_divider) enables
//             gradual underflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module potential_decay_engine
    import potential_decay_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int RATE_WIDTH  = 3,
    parameter int ADDR_WIDTH  = $clog2(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  rate_wr_en,
    input  logic [ADDR_WIDTH-1:0] rate_addr,
    input  logic [RATE_WIDTH-1:0] rate_data,
    input  logic                  timestep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [31:0]           out_potential,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]           rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(NUM_NEURONS - 1);

    logic [31:0]           r_pot  [NUM_NEURONS];
    logic [RATE_WIDTH-1:0] r_rate [NUM_NEURONS];

    sweep_state_t          r_state;
    sweep_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_issued_all;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [31:0]           r_out_pot;
    logic                  r_done;
    logic                  r_overrun;
    logic [31:0]           r_rd_data;

    logic                  w_issue;
    logic                  w_sweep_end;
    logic                  w_start;
    logic [31:0]           w_cur_pot;
    logic [RATE_WIDTH-1:0] w_cur_rate;
    logic [31:0]           w_decayed;
    logic                  w_wb_blocked;
    logic [31:0]           w_rd_next;

    assign w_cur_pot  = r_pot[r_ptr];
    assign w_cur_rate = r_rate[r_ptr];

    fp32_pow2_divider #(
        .RATE_WIDTH (RATE_WIDTH)
    ) u_divider (
        .i_value  (w_cur_pot),
        .i_rate   (w_cur_rate),
        .o_result (w_decayed)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, issue qualification and end-of-sweep detection.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_sweep_end  = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (timestep) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_issue = !r_issued_all && (!r_out_valid || out_ready);
                if (r_out_valid && out_ready && (r_out_addr == c_last_idx)) begin
                    w_sweep_end  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sweep pointer and the single-entry output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_issued_all <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_out_pot    <= '0;
        end else begin
            if (w_start) begin
                r_ptr        <= '0;
                r_issued_all <= 1'b0;
            end
            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= r_ptr;
                r_out_pot   <= w_decayed;
                if (r_ptr == c_last_idx) begin
                    r_ptr        <= '0;
                    r_issued_all <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // An external write to the entry being issued takes precedence over writeback.
    assign w_wb_blocked = wr_en && (wr_addr == r_ptr);

    // Potential and rate tables: sweep writeback plus external writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_pot[i]  <= '0;
                r_rate[i] <= '0;
            end
        end else begin
            if (w_issue && !w_wb_blocked) begin
                r_pot[r_ptr] <= w_decayed;
            end
            if (wr_en) begin
                r_pot[wr_addr] <= wr_data;
            end
            if (rate_wr_en) begin
                r_rate[rate_addr] <= rate_data;
            end
        end
    end

    // Read port returns the entry as it stands after this cycle's writes.
    always_comb begin
        w_rd_next = r_pot[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            w_rd_next = wr_data;
        end else if (w_issue && (r_ptr == rd_addr)) begin
            w_rd_next = w_decayed;
        end
    end

    // Registered read data, end-of-sweep pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rd_data <= w_rd_next;
            r_done    <= w_sweep_end;
            if ((r_state == ST_SWEEP) && timestep) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_addr      = r_out_addr;
    assign out_potential = r_out_pot;
    assign rd_data       = r_rd_data;
    assign busy          = (r_state == ST_SWEEP);
    assign done          = r_done;
    assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_potential_decay_engine.sv
// ============================================================================
//  Module   : tb_potential_decay_engine
//  Purpose  : Scoreboard bench for potential_decay_engine with a behavioural
//             FP32 decay model. Honours POTENTIAL_DECAY_SUBNORMAL_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_potential_decay_engine;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          rate_wr_en;
    logic [AW-1:0] rate_addr;
    logic [RW-1:0] rate_data;
    logic          timestep;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_potential;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          busy;
    logic          done;
    logic          overrun;

    potential_decay_engine #(
        .NUM_NEURONS (N),
        .RATE_WIDTH  (RW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rate_wr_en    (rate_wr_en),
        .rate_addr     (rate_addr),
        .rate_data     (rate_data),
        .timestep      (timestep),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_potential (out_potential),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   val;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_item;
    int            n_cmp    = 0;
    int            n_bad    = 0;
    int            hs_count = 0;
    logic [31:0]   mpot  [N];
    int            mrate [N];
    logic          held = 1'b0;
    logic [AW-1:0] held_addr;
    logic [31:0]   held_pot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Value / 2^r from the FP32 definition: shrink the exponent while the
    // result stays normal, otherwise re-express it in subnormal units.
    function automatic logic [31:0] model_decay(input logic [31:0] v, input int r);
        int          e;
        logic [22:0] m;
        e = int'(v[30:23]);
        m = v[22:0];
        if (r == 0 || e == 255) return v;
        if (e > r) return {v[31], 8'(e - r), m};
`ifdef POTENTIAL_DECAY_SUBNORMAL_EN
        begin
            longint sig;
            int     eff;
            eff = (e == 0) ? 1 : e;
            sig = (e == 0) ? longint'(m) : (longint'(m) + (longint'(1) << 23));
            sig = sig >> (r - eff + 1);
            return {v[31], 8'd0, 23'(sig)};
        end
`else
        return {v[31], 31'd0};
`endif
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    always @(negedge clk) begin
        if (!reset) begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_addr", 32'(out_addr), 32'(held_addr));
                check("hold_data", out_potential, held_pot);
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("out_addr", 32'(out_addr), 32'(mon_item.addr));
                    check("out_data", out_potential, mon_item.val);
                end
            end
            held      = out_valid && !out_ready;
            held_addr = out_addr;
            held_pot  = out_potential;
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pot(input int addr, input logic [31:0] val);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = val;
        tick();
        wr_en   = 1'b0;
        mpot[addr] = val;
    endtask

    task automatic write_rate(input int addr, input int r);
        rate_wr_en = 1'b1;
        rate_addr  = AW'(addr);
        rate_data  = RW'(r);
        tick();
        rate_wr_en = 1'b0;
        mrate[addr] = r;
    endtask

    task automatic read_tab(input int addr, output logic [31:0] val);
        rd_addr = AW'(addr);
        tick();
        val = rd_data;
    endtask

    task automatic push_sweep();
        exp_t item;
        for (int i = 0; i < N; i++) begin
            item.addr = AW'(i);
            item.val  = model_decay(mpot[i], mrate[i]);
            exp_q.push_back(item);
            mpot[i] = item.val;
        end
    endtask

    // mode 0: ready=1; mode 1: random ready; mode 2: ready=0 for 5 cycles.
    task automatic run_sweep(input int mode, input int ts_again_k,
                             output int fv_k, output int dn_k);
        push_sweep();
        fv_k      = -1;
        dn_k      = -1;
        timestep  = 1'b1;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 1; k <= 300 && dn_k < 0; k++) begin
            @(posedge clk);
            #1;
            timestep = (k == ts_again_k);
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(k >= 6 && k <= 10);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (k == 1) check("busy_in_sweep", 32'(busy), 32'd1);
            if (fv_k < 0 && out_valid) fv_k = k;
            if (done) begin
                dn_k = k;
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
        check("sweep_completed", 32'(dn_k >= 0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          fv;
        int          dn;
        int          hs0;
        logic [31:0] val;
        logic        done_seen;

        for (int i = 0; i < N; i++) begin
            mpot[i]  = 32'd0;
            mrate[i] = 0;
        end
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rate_wr_en = 1'b0;
        rate_addr  = '0;
        rate_data  = '0;
        timestep   = 1'b0;
        out_ready  = 1'b1;
        rd_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_potential", out_potential, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        reset = 1'b0;
        tick();

        // Single-element example with timing.
        write_pot(0, 32'h41200000);
        write_rate(0, 4);
        run_sweep(0, 0, fv, dn);
        check("ex_first_valid_cycle", 32'(fv), 32'd2);
        check("ex_done_cycle", 32'(dn), 32'd18);
        read_tab(0, val);
        check("ex_readback0", val, 32'h3F200000);

        // Uniform table: 2.0 halved everywhere, one result per cycle.
        for (int i = 0; i < N; i++) begin
            write_pot(i, 32'h40000000);
            write_rate(i, 1);
        end
        hs0 = hs_count;
        run_sweep(0, 0, fv, dn);
        check("uni_first_valid_cycle", 32'(fv), 32'd2);
        check("uni_done_cycle", 32'(dn), 32'd18);
        check("uni_output_count", 32'(hs_count - hs0), 32'd16);
        read_tab(15, val);
        check("uni_readback15", val, 32'h3F800000);

        // Underflow and Inf cases.
        write_pot(1, 32'h00800000);  write_rate(1, 2);
        write_pot(2, 32'h80800000);  write_rate(2, 2);
        write_pot(3, 32'h7F800000);  write_rate(3, 7);
        write_pot(4, 32'h00000123);  write_rate(4, 1);
        write_pot(5, 32'h3F800000);  write_rate(5, 7);
        run_sweep(0, 0, fv, dn);
        read_tab(1, val);
`ifdef POTENTIAL_DECAY_SUBNORMAL_EN
        check("uflow_pos", val, 32'h00200000);
`else
        check("uflow_pos", val, 32'h00000000);
        read_tab(2, val);
        check("uflow_neg", val, 32'h80000000);
`endif
        read_tab(3, val);
        check("inf_passthru", val, 32'h7F800000);

        // Randomised tables with random back-pressure.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < N; i++) begin
                int unsigned e;
                e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
                write_pot(i, {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)});
                write_rate(i, int'($urandom_range(0, 7)));
            end
            run_sweep(1, 0, fv, dn);
        end

        // Five stalled cycles mid-sweep delay DONE by five.
        hs0 = hs_count;
        run_sweep(2, 0, fv, dn);
        check("stall_done_cycle", 32'(dn), 32'd23);
        check("stall_output_count", 32'(hs_count - hs0), 32'd16);

        // TIMESTEP during a sweep sets OVERRUN and is otherwise ignored.
        check("overrun_before", 32'(overrun), 32'd0);
        hs0 = hs_count;
        run_sweep(0, 3, fv, dn);
        check("overrun_after", 32'(overrun), 32'd1);
        check("overrun_output_count", 32'(hs_count - hs0), 32'd16);
        check("overrun_done_cycle", 32'(dn), 32'd18);
        repeat (4) tick();
        check("overrun_no_extra_sweep", 32'(busy), 32'd0);

        for (int i = 0; i < N; i++) begin
            read_tab(i, val);
            check($sformatf("readback%0d", i), val, mpot[i]);
        end

        // Reset in the middle of a sweep.
        push_sweep();
        timestep = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            timestep = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            mpot[i]  = 32'd0;
            mrate[i] = 0;
        end
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        done_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        tick();
        check("abort_no_done", 32'(done_seen), 32'd0);
        for (int i = 0; i < N; i++) begin
            read_tab(i, val);
            check($sformatf("abort_readback%0d", i), val, mpot[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/potential_decay_engine.md
POTENTIAL_DECAY_ENGINE -- requirements
Module: potential_decay_engine

Interface
REQ-001 Parameter NUM_NEURONS, default 16: number of neuron potentials held, at least 2.
REQ-002 Parameter RATE_WIDTH, default 3: width of each per-neuron decay rate; a rate of r divides the potential by 2^r.
REQ-003 Parameter ADDR_WIDTH, default $clog2(NUM_NEURONS): neuron index width.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 WR_EN / WR_ADDR / WR_DATA  in  1 / ADDR_WIDTH / 32  write an IEEE-754 single potential into the neuron table.
REQ-007 RATE_WR_EN / RATE_ADDR / RATE_DATA  in  1 / ADDR_WIDTH / RATE_WIDTH  write a per-neuron decay rate.
REQ-008 TIMESTEP  in  1  single-cycle pulse that starts one decay sweep over all neurons.
REQ-009 OUT_VALID / OUT_READY  out / in  1 / 1  valid/ready handshake for the decayed-potential stream.
REQ-010 OUT_ADDR / OUT_POTENTIAL  out  ADDR_WIDTH / 32  neuron index and decayed value; stable while OUT_VALID=1 and OUT_READY=0.
REQ-011 RD_ADDR / RD_DATA  in / out  ADDR_WIDTH / 32  registered read of the table with 1-cycle latency.
REQ-012 BUSY / DONE / OVERRUN  out  1 / 1 / 1  sweep active / one-cycle end-of-sweep pulse / sticky flag for TIMESTEP received while busy.

Function
REQ-013 FSM states: IDLE and SWEEP. IDLE goes to SWEEP on TIMESTEP. SWEEP goes to IDLE after the handshake of index NUM_NEURONS-1.
REQ-014 BUSY shall be 1 exactly while in SWEEP.
REQ-015 DONE shall pulse in the cycle after the last handshake, coincident with BUSY falling.
REQ-016 Sweep pointer: starts at 0 and increments by 1 each time an element is issued.
REQ-017 An element is issued when the output register is empty or is handshaking in the same cycle. The output register gives 1-cycle latency from issue to OUT_VALID.
REQ-018 Throughput: with OUT_READY tied to 1, one result per cycle. TIMESTEP at cycle t gives outputs at cycles t+2 .. t+NUM_NEURONS+1 and DONE at t+NUM_NEURONS+2.
REQ-019 Each decayed value shall be written back to its table entry in the cycle it is issued.
REQ-020 Decay arithmetic, with sign s, exponent e, mantissa m and rate r:
  - r=0: value unchanged.
  - e=255 (Inf/NaN): value unchanged.
  - e>r: exponent becomes e-r; s and m unchanged.
  - otherwise: underflow, handled per REQ-030.
  - Example: 0x41200000 with r=4 gives 0x3F200000.
REQ-021 If WR_EN and a sweep writeback target the same address in the same cycle, the external write wins. The streamed value is still the decayed one.
REQ-022 WR_EN and RATE_WR_EN shall be accepted in any state. A write to an index not yet issued in the current sweep is seen by that sweep.
REQ-023 TIMESTEP while BUSY shall be ignored and shall set OVERRUN. OVERRUN clears only on RESET.
REQ-024 RD_DATA shall return the table content after that cycle's writes: new data visible on the next read.

Reset
REQ-025 On RESET: FSM goes to IDLE; pointer is 0; all potentials are +0.0 (0x00000000); all rates are 0.
REQ-026 On RESET: OUT_VALID, BUSY, DONE and OVERRUN are 0; OUT_ADDR, OUT_POTENTIAL and RD_DATA are 0.
REQ-027 RESET asserted mid-sweep shall abort the sweep with no DONE pulse and drop any pending OUT_VALID.
REQ-028 RESET shall take priority over WR_EN, RATE_WR_EN and TIMESTEP in the same cycle.

Configuration
REQ-029 Macro POTENTIAL_DECAY_SUBNORMAL_EN compiles in gradual underflow.
REQ-030 Underflow behaviour, selected by the macro:
  - Defined: an underflowing normal value yields exponent 0 and mantissa ({1,m} >> (r-e+1)), truncated. A subnormal input (e=0) yields m >> r.
  - Undefined: an underflowing or subnormal input yields signed zero {s,31'b0}.

Structure
REQ-031 Shared package potential_decay_pkg holds:
  - FP32 field-position constants and the EXP_MAX=255 constant;
  - the sweep state enum typedef;
  - the decay_fp32(value, rate) function.
REQ-032 One sub-module, fp32_pow2_divider: combinational decay datapath, parametrised on RATE_WIDTH, instanced once. The macro of REQ-029 applies inside it.

Verification
REQ-033 Load 0x41200000, rate 4 at index 0; pulse TIMESTEP with OUT_READY=1 -> index 0 streams 0x3F200000; a readback of index 0 returns 0x3F200000.
REQ-034 NUM_NEURONS=16, all rates 1, all values 0x40000000, OUT_READY=1 -> 16 consecutive outputs of 0x3F800000 at cycles t+2..t+17, OUT_ADDR 0..15, DONE at t+18.
REQ-035 Hold OUT_READY=0 for 5 cycles mid-sweep -> OUT_VALID, OUT_ADDR and OUT_POTENTIAL stay stable; no index skipped or duplicated; DONE is delayed by 5 cycles.
REQ-036 Value 0x00800000 (e=1), rate 2:
  - without the macro -> output 0x00000000;
  - value 0x80800000 without the macro -> output 0x80000000;
  - with the macro -> 0x00800000 gives 0x00200000.
REQ-037 0x7F800000 with rate 7 -> output unchanged.
REQ-038 TIMESTEP pulsed at sweep cycle 3 -> OVERRUN=1 and still exactly 16 outputs.
REQ-039 RESET asserted at sweep cycle 6 -> OUT_VALID=0, BUSY=0, no DONE pulse, readback of every index returns 0x00000000.
